// File: rtl/axi_line_xfer.sv
// AXI4 INCR burst master moving one cache line between the line shift FIFO and memory.
// Optional watchdog escape enabled by defining AXI_XFER_TIMEOUT_EN.
module axi_line_xfer #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BLOCK_WIDTH    = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_start_read,
    input  logic                        i_start_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   i_wb_data,
    output logic                        o_rd_active,
    output logic                        o_wr_active,
    output logic                        o_beat_valid,
    output logic [AXI_DATA_WIDTH-1:0]   o_beat_data,
    output logic                        o_wb_shift,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error,
    output logic                        o_arvalid,
    input  logic                        i_arready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_araddr,
    output logic [7:0]                  o_arlen,
    output logic [2:0]                  o_arsize,
    output logic [1:0]                  o_arburst,
    input  logic                        i_rvalid,
    output logic                        o_rready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]                  i_rresp,
    input  logic                        i_rlast,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    output logic                        o_wlast,
    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [1:0]                  i_bresp
);

    localparam int BEATS       = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int BLOCK_BYTES = BLOCK_WIDTH / 8;
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [AXI_ADDR_WIDTH-1:0] OFF_MASK = AXI_ADDR_WIDTH'(BLOCK_BYTES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_ADDR = 3'd3;
    localparam logic [2:0] S_WR_DATA = 3'd4;
    localparam logic [2:0] S_WR_RESP = 3'd5;

    if ((BLOCK_WIDTH % AXI_DATA_WIDTH) != 0 || BEATS > 256 || AXI_DATA_WIDTH < 8 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("axi_line_xfer: invalid parameter set");
    end

    logic [2:0]                state;
    logic [CNT_W-1:0]          cnt;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic                      err;
    logic                      done;
    logic                      last_beat;
    logic                      timeout;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));

`ifdef AXI_XFER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog;
    logic            hs;

    // Handshake on whichever channel the current state is waiting on.
    always_comb begin
        hs = 1'b0;
        case (state)
            S_RD_ADDR: hs = i_arready;
            S_RD_DATA: hs = i_rvalid;
            S_WR_ADDR: hs = i_awready;
            S_WR_DATA: hs = i_wready;
            S_WR_RESP: hs = i_bvalid;
            default:   hs = 1'b0;
        endcase
    end

    assign timeout = (state != S_IDLE) && !hs && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rstn || state == S_IDLE || hs || timeout) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
            addr  <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (timeout) begin
                state <= S_IDLE;
                done  <= 1'b1;
                err   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start_write || i_start_read) begin
                            state <= i_start_write ? S_WR_ADDR : S_RD_ADDR;
                            addr  <= i_addr & ~OFF_MASK;
                            cnt   <= '0;
                            err   <= 1'b0;
                        end
                    end
                    S_RD_ADDR: if (i_arready) state <= S_RD_DATA;
                    S_RD_DATA: begin
                        if (i_rvalid) begin
                            cnt <= cnt + 1'b1;
                            // Counter decides burst end; a disagreeing rlast only flags an error.
                            if (i_rresp != 2'b00 || i_rlast != last_beat) err <= 1'b1;
                            if (last_beat) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_WR_ADDR: if (i_awready) state <= S_WR_DATA;
                    S_WR_DATA: begin
                        if (i_wready) begin
                            cnt <= cnt + 1'b1;
                            if (last_beat) state <= S_WR_RESP;
                        end
                    end
                    S_WR_RESP: begin
                        if (i_bvalid) begin
                            if (i_bresp != 2'b00) err <= 1'b1;
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_rd_active  = (state == S_RD_ADDR) || (state == S_RD_DATA);
    assign o_wr_active  = (state == S_WR_ADDR) || (state == S_WR_DATA) || (state == S_WR_RESP);
    assign o_busy       = (state != S_IDLE);
    assign o_done       = done;
    assign o_error      = err;

    assign o_arvalid    = (state == S_RD_ADDR);
    assign o_araddr     = addr;
    assign o_arlen      = 8'(BEATS - 1);
    assign o_arsize     = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign o_arburst    = 2'b01;

    assign o_rready     = (state == S_RD_DATA);
    assign o_beat_valid = (state == S_RD_DATA) && i_rvalid;
    assign o_beat_data  = i_rdata;

    assign o_awvalid    = (state == S_WR_ADDR);
    assign o_awaddr     = addr;
    assign o_awlen      = 8'(BEATS - 1);
    assign o_awsize     = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign o_awburst    = 2'b01;

    assign o_wvalid     = (state == S_WR_DATA);
    assign o_wdata      = i_wb_data;
    assign o_wstrb      = '1;
    assign o_wlast      = (state == S_WR_DATA) && last_beat;
    assign o_wb_shift   = (state == S_WR_DATA) && i_wready;

    assign o_bready     = (state == S_WR_RESP);

endmodule

// File: tb/tb_axi_line_xfer.sv
// Scoreboard bench for axi_line_xfer: fills, writebacks, error paths, reset abort, watchdog.
module tb_axi_line_xfer;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_read, start_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wb_data;
    logic          rd_active, wr_active, beat_valid, wb_shift, busy, done, error;
    logic [DW-1:0] beat_data;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [AW-1:0] araddr, awaddr;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize;
    logic [1:0]    arburst, awburst, rresp, bresp;
    logic [DW-1:0] rdata, wdata;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [DW/8-1:0] wstrb;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] wr_q[$];

    always #5 clk = ~clk;

    axi_line_xfer #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .BLOCK_WIDTH   (512),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start_read(start_read), .i_start_write(start_write),
        .i_addr(addr), .i_wb_data(wb_data), .o_rd_active(rd_active), .o_wr_active(wr_active),
        .o_beat_valid(beat_valid), .o_beat_data(beat_data), .o_wb_shift(wb_shift),
        .o_busy(busy), .o_done(done), .o_error(error),
        .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arlen(arlen),
        .o_arsize(arsize), .o_arburst(arburst),
        .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
        .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awlen(awlen),
        .o_awsize(awsize), .o_awburst(awburst),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
        .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Fill beats are compared against the scoreboard as the DUT strobes them.
    always @(negedge clk) begin
        if (beat_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                check("beat_unexpected", 64'(beat_data), 64'hDEAD);
            end else begin
                check("beat_data", 64'(beat_data), 64'(rd_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit gap, input int bad_beat,
                           input int rlast_beat, input int abort_at, input bit exp_err);
        int n;
        addr       = a;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        n = 0;
        @(negedge clk);
        while (arvalid !== 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("arvalid", 64'(arvalid), 64'd1);
        check("araddr", 64'(araddr), 64'(a & ~32'h3F));
        check("ar_fields", {arlen, 1'b0, arsize, 2'b00, arburst}, {8'd15, 1'b0, 3'd2, 2'b00, 2'b01});
        check("rd_active", 64'(rd_active), 64'd1);
        tick();
        arready = 1'b1;
        @(negedge clk);
        check("araddr_hold", 64'(araddr), 64'(a & ~32'h3F));
        tick();
        arready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (b == abort_at) begin
                rstn = 1'b0;
                tick();
                rstn = 1'b1;
                @(negedge clk);
                check("abort_rready", 64'(rready), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                tick();
                @(negedge clk);
                check("abort_done_late", 64'(done), 64'd0);
                return;
            end
            if (gap) tick();
            rvalid = 1'b1;
            rdata  = DW'(b);
            rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (b == rlast_beat);
            rd_q.push_back(DW'(b));
            @(negedge clk);
            check("rready", 64'(rready), 64'd1);
            check("rd_done_early", 64'(done), 64'd0);
            tick();
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
        @(negedge clk);
        check("rd_done", 64'(done), 64'd1);
        check("rd_error", 64'(error), 64'(exp_err));
        check("rd_busy", 64'(busy), 64'd0);
        check("rd_q_empty", 64'(rd_q.size()), 64'd0);
        tick();
        @(negedge clk);
        check("rd_done_pulse", 64'(done), 64'd0);
        check("rd_error_hold", 64'(error), 64'(exp_err));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int aw_delay, input bit both,
                            input logic [1:0] resp, input bit exp_err, input bit wait_b);
        int idx;
        int cyc;
        addr        = a;
        start_write = 1'b1;
        start_read  = both;
        tick();
        start_write = 1'b0;
        for (int i = 0; i < 16; i++) wr_q.push_back(32'hA0 + DW'(i));
        @(negedge clk);
        check("awvalid", 64'(awvalid), 64'd1);
        check("aw_vs_ar", 64'(arvalid), 64'd0);
        check("aw_fields", {awlen, 1'b0, awsize, 2'b00, awburst}, {8'd15, 1'b0, 3'd2, 2'b00, 2'b01});
        check("wstrb", 64'(wstrb), 64'hF);
        for (int d = 0; d < aw_delay; d++) begin
            @(negedge clk);
            check("aw_hold", {awvalid, wvalid}, 2'b10);
            check("awaddr", 64'(awaddr), 64'(a & ~32'h3F));
            tick();
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 200) begin
            wb_data = 32'hA0 + DW'(idx);
            wready  = (cyc % 3) != 2;
            @(negedge clk);
            check("wvalid", 64'(wvalid), 64'd1);
            if (wready) begin
                check("wdata", 64'(wdata), 64'(wr_q.pop_front()));
                check("wlast", 64'(wlast), 64'(idx == 15));
                check("wb_shift", 64'(wb_shift), 64'd1);
            end else begin
                check("wb_shift_idle", 64'(wb_shift), 64'd0);
            end
            tick();
            if (wready) idx++;
            cyc++;
        end
        wready = 1'b0;
        check("w_beats", 64'(idx), 64'd16);
        @(negedge clk);
        check("bready", {bready, wvalid, wr_active}, 3'b101);
        if (!wait_b) return;
        tick();
        bvalid = 1'b1;
        bresp  = resp;
        tick();
        bvalid = 1'b0;
        bresp  = 2'b00;
        @(negedge clk);
        check("wr_done", 64'(done), 64'd1);
        check("wr_error", 64'(error), 64'(exp_err));
        if (!both) begin
            tick();
            @(negedge clk);
            check("wr_done_pulse", {done, busy}, 2'b00);
        end
    endtask

    initial begin
        rstn = 1'b0; start_read = 1'b0; start_write = 1'b0; addr = '0; wb_data = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        repeat (3) tick();
        @(negedge clk);
        check("rst_state", {busy, done, error, arvalid, awvalid, wvalid, rready, bready},
              8'h00);
        tick();
        rstn = 1'b1;
        tick();

        do_read(32'h0000_1234, 1'b1, 99, 15, 99, 1'b0);
        do_write(32'h8000_0040, 3, 1'b0, 2'b00, 1'b0, 1'b1);
        do_write(32'h1000_0080, 0, 1'b1, 2'b00, 1'b0, 1'b1);
        do_read(32'h1000_0080, 1'b0, 99, 15, 99, 1'b0);
        do_read(32'h0000_4400, 1'b0, 4, 15, 99, 1'b1);
        do_read(32'h0000_4440, 1'b1, 99, 9, 99, 1'b1);
        do_write(32'h2222_22C7, 1, 1'b0, 2'b10, 1'b1, 1'b1);
        do_read(32'h0000_0100, 1'b0, 99, 15, 7, 1'b0);
        do_read(32'h0000_0140, 1'b0, 99, 15, 99, 1'b0);

`ifdef AXI_XFER_TIMEOUT_EN
        do_write(32'h0000_0200, 0, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            @(negedge clk);
            if (k < 9) begin
                check("wd_wait", {done, bready}, 2'b01);
            end else begin
                check("wd_fire", {done, error, busy, bready}, 4'b1100);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/axi_line_xfer.md
Name: axi_line_xfer

Overview:
AXI4 burst master that moves one cache line between the cache and memory. It sits directly upstream of the line shift FIFO.
- Line fill: issues an INCR read burst and streams each R beat into the FIFO.
- Writeback: issues an INCR write burst, sourcing each W beat from the FIFO's lowest word and requesting a FIFO shift per accepted beat.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width.
AXI_DATA_WIDTH, 32, AXI data bus width; power of two, minimum 8.
BLOCK_WIDTH, 512, cache line width in bits; integer multiple of AXI_DATA_WIDTH.
TIMEOUT_CYCLES, 1024, watchdog limit; used only with AXI_XFER_TIMEOUT_EN.
Derived: BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH (max 256); BLOCK_BYTES = BLOCK_WIDTH/8.

Ports:
i_clk  in  1  clock
i_rstn  in  1  synchronous active-low reset
i_start_read  in  1  request line fill (sampled in IDLE only)
i_start_write  in  1  request writeback (sampled in IDLE only)
i_addr  in  AXI_ADDR_WIDTH  line address
i_wb_data  in  AXI_DATA_WIDTH  current lowest FIFO word
o_rd_active  out  1  high while in RD_ADDR or RD_DATA (drives FIFO start_read)
o_wr_active  out  1  high while in WR_ADDR, WR_DATA or WR_RESP (drives FIFO start_write)
o_beat_valid  out  1  fill beat strobe (FIFO write enable)
o_beat_data  out  AXI_DATA_WIDTH  fill beat data
o_wb_shift  out  1  writeback beat consumed; FIFO shifts
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle completion pulse
o_error  out  1  error status for the completed transfer
AR channel: o_arvalid out 1; i_arready in 1; o_araddr out AXI_ADDR_WIDTH; o_arlen out 8; o_arsize out 3; o_arburst out 2
R channel: i_rvalid in 1; o_rready out 1; i_rdata in AXI_DATA_WIDTH; i_rresp in 2; i_rlast in 1
AW channel: o_awvalid out 1; i_awready in 1; o_awaddr out AXI_ADDR_WIDTH; o_awlen out 8; o_awsize out 3; o_awburst out 2
W channel: o_wvalid out 1; i_wready in 1; o_wdata out AXI_DATA_WIDTH; o_wstrb out AXI_DATA_WIDTH/8; o_wlast out 1
B channel: i_bvalid in 1; o_bready out 1; i_bresp in 2

Behaviour:
- Reset (i_rstn low at a clock edge): state IDLE, beat counter 0, every valid/ready/strobe low, o_done 0, o_error 0, o_busy 0. Applies mid-burst too: transfer abandoned, no o_done.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE:
  - i_start_write goes to WR_ADDR. Otherwise i_start_read goes to RD_ADDR. Write wins when both are high.
  - On start, latch address = i_addr with the low log2(BLOCK_BYTES) bits cleared; clear counter and error flag.
  - Starts are ignored in all other states.
- Burst fields:
  - arlen/awlen = BEATS-1.
  - arsize/awsize = log2(AXI_DATA_WIDTH/8).
  - arburst/awburst = 2'b01.
  - wstrb all ones.
- RD_ADDR: o_arvalid=1 with the latched address. o_arvalid and o_araddr stay stable until i_arready; on handshake go to RD_DATA.
- RD_DATA:
  - o_rready=1.
  - On i_rvalid: o_beat_valid=1 combinationally in the same cycle; o_beat_data=i_rdata; counter increments.
  - i_rresp != 0 sets the sticky error flag.
  - i_rlast != (counter==BEATS-1) sets the error flag. The counter is authoritative.
  - Handshake at counter BEATS-1 goes to IDLE.
- WR_ADDR: o_awvalid held until i_awready, then go to WR_DATA. o_wvalid stays 0 in WR_ADDR.
- WR_DATA:
  - o_wvalid=1; o_wdata=i_wb_data; o_wlast=(counter==BEATS-1).
  - On i_wready: o_wb_shift=1 combinationally; counter increments.
  - o_wvalid never drops before the handshake.
  - Last handshake goes to WR_RESP.
- WR_RESP: o_bready=1. On i_bvalid, set error if i_bresp != 0, then go to IDLE.
- Completion: o_done is a registered pulse in the cycle after the final R or B handshake. o_error is valid with o_done and holds until the next accepted start.
- Back-to-back: a start may be accepted in the cycle o_done is high.
- o_rd_active/o_wr_active are decoded from state.

Optional Feature:
AXI_XFER_TIMEOUT_EN
- Defined:
  - A watchdog counts consecutive cycles in any non-IDLE state with no handshake on the active channel; it clears on each handshake.
  - At TIMEOUT_CYCLES: go to IDLE, pulse o_done, set o_error=1, and drop all valids/readies. AXI protocol is violated deliberately; this is a debug escape.
- Undefined: no watchdog logic; the FSM waits indefinitely.

Test Plan:
1. Read fill: start_read, i_addr=0x00001234 -> o_araddr=0x00001200, arlen=15, arsize=2, arburst=1. Feed 16 beats rdata=0..15 with rvalid gapped every other cycle and rlast on beat 16 -> 16 o_beat_valid pulses carrying 0..15 in order, o_done one cycle after beat 16, o_error=0.
2. Writeback: start_write, i_addr=0x80000040; awready delayed 3 cycles; model FIFO shifts 0xA0..0xAF -> awvalid held for 3 cycles with stable address, wdata=0xA0..0xAF, 16 o_wb_shift pulses, wlast only on the 16th beat, bresp=0 -> o_done with o_error=0.
3. start_read and start_write both high in IDLE -> o_awvalid=1, o_arvalid=0; after write completion with start_read still high, the read begins.
4. Read with rresp=2'b10 on beat 5 -> all 16 beats accepted, o_error=1 with o_done. Separately, rlast on beat 10 -> o_error=1.
5. i_rstn low for 1 cycle after read beat 7 -> next cycle o_rready=0, o_busy=0, no o_done. A new read then runs cleanly.
6. AXI_XFER_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, bvalid never asserted -> o_done and o_error 8 cycles after entering WR_RESP, then state IDLE.
